// File: rtl/ext_bus_arbiter_if.sv
// Requester-side and pin-side signals of the external byte-serial memory port arbiter.
// slave = arbiter view, master = the requesters / pin wrapper view.
interface ext_bus_arbiter_if;
    logic        req0;
    logic        rw0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        ack0;
    logic        req1;
    logic        rw1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        ack1;
    logic [31:0] rdata;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic [7:0]  bus_oe;
    logic [1:0]  bus_phase;
    logic [1:0]  bus_byte;
    logic        busy;

    modport slave (
        input  req0, rw0, addr0, wdata0,
        input  req1, rw1, addr1, wdata1,
        input  bus_din,
        output ack0, ack1, rdata,
        output bus_addr, bus_dout, bus_oe, bus_phase, bus_byte, busy
    );

    modport master (
        output req0, rw0, addr0, wdata0,
        output req1, rw1, addr1, wdata1,
        output bus_din,
        input  ack0, ack1, rdata,
        input  bus_addr, bus_dout, bus_oe, bus_phase, bus_byte, busy
    );
endinterface

// File: rtl/ext_bus_arbiter.sv
// Two-port arbiter for the byte-serial external memory port: grants one 32-bit
// request, shifts address/write data out LSB first, captures read data, then acks.
module ext_bus_arbiter #(
    parameter int TURN_CYCLES = 1,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    ext_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_TURN, S_RDATA, S_DONE} state_t;

    localparam logic [2:0] TC = 3'(TURN_CYCLES);

    state_t      r_state;
    logic [1:0]  r_byte;
    logic [2:0]  r_tcnt;
    logic        r_rw;
    logic        r_gnt;
    logic        r_last;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [23:0] r_shadow;

    logic        r_ack0;
    logic        r_ack1;
    logic [31:0] r_rdata;
    logic [7:0]  r_bus_addr;
    logic [7:0]  r_bus_dout;
    logic [7:0]  r_bus_oe;
    logic [1:0]  r_bus_phase;
    logic [1:0]  r_bus_byte;
    logic        r_busy;

    logic        w_any;
    logic        w_gnt;
    logic        w_rw;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_nbyte;
    logic [4:0]  w_sh;
    logic [7:0]  w_addr_nb;
    logic [7:0]  w_wd_nb;

    // Tie-break: round-robin favours the port not granted last time.
    always_comb begin
        w_any = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1)
            w_gnt = FIXED_PRIO ? 1'b0 : ~r_last;
        else
            w_gnt = bus.req1;
        w_rw      = w_gnt ? bus.rw1    : bus.rw0;
        w_addr    = w_gnt ? bus.addr1  : bus.addr0;
        w_wdata   = w_gnt ? bus.wdata1 : bus.wdata0;
        w_nbyte   = r_byte + 2'd1;
        w_sh      = {w_nbyte, 3'b000};
        w_addr_nb = 8'(r_addr  >> w_sh);
        w_wd_nb   = 8'(r_wdata >> w_sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_byte      <= 2'd0;
            r_tcnt      <= 3'd0;
            r_rw        <= 1'b0;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_shadow    <= 24'h0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata     <= 32'h0;
            r_bus_addr  <= 8'h00;
            r_bus_dout  <= 8'h00;
            r_bus_oe    <= 8'h00;
            r_bus_phase <= 2'b00;
            r_bus_byte  <= 2'd0;
            r_busy      <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_ADDR;
                        r_byte      <= 2'd0;
                        r_rw        <= w_rw;
                        r_gnt       <= w_gnt;
                        r_last      <= w_gnt;
                        r_addr      <= w_addr;
                        r_wdata     <= w_wdata;
                        r_busy      <= 1'b1;
                        r_bus_phase <= 2'b01;
                        r_bus_byte  <= 2'd0;
                        r_bus_addr  <= w_addr[7:0];
                        r_bus_dout  <= w_rw ? 8'h00 : w_wdata[7:0];
                        r_bus_oe    <= w_rw ? 8'h00 : 8'hFF;
                    end
                end
                S_ADDR: begin
                    if (r_byte == 2'd3) begin
                        r_bus_addr <= 8'h00;
                        r_bus_dout <= 8'h00;
                        r_bus_oe   <= 8'h00;
                        r_bus_byte <= 2'd0;
                        if (r_rw) begin
                            r_state     <= S_TURN;
                            r_tcnt      <= 3'd1;
                            r_bus_phase <= 2'b10;
                        end else begin
                            r_state     <= S_DONE;
                            r_bus_phase <= 2'b00;
                            r_ack0      <= ~r_gnt;
                            r_ack1      <= r_gnt;
                        end
                    end else begin
                        r_byte     <= w_nbyte;
                        r_bus_byte <= w_nbyte;
                        r_bus_addr <= w_addr_nb;
                        r_bus_dout <= r_rw ? 8'h00 : w_wd_nb;
                    end
                end
                S_TURN: begin
                    if (r_tcnt == TC) begin
                        r_state     <= S_RDATA;
                        r_byte      <= 2'd0;
                        r_bus_phase <= 2'b11;
                        r_bus_byte  <= 2'd0;
                    end else begin
                        r_tcnt <= r_tcnt + 3'd1;
                    end
                end
                S_RDATA: begin
                    // Bytes arrive LSB first; the shadow shifts right so byte 3 lands on top.
                    if (r_byte == 2'd3) begin
                        r_state     <= S_DONE;
                        r_rdata     <= {bus.bus_din, r_shadow};
                        r_bus_phase <= 2'b00;
                        r_bus_byte  <= 2'd0;
                        r_ack0      <= ~r_gnt;
                        r_ack1      <= r_gnt;
                    end else begin
                        r_shadow   <= {bus.bus_din, r_shadow[23:8]};
                        r_byte     <= w_nbyte;
                        r_bus_byte <= w_nbyte;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata     = r_rdata;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_dout  = r_bus_dout;
    assign bus.bus_oe    = r_bus_oe;
    assign bus.bus_phase = r_bus_phase;
    assign bus.bus_byte  = r_bus_byte;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Bench for ext_bus_arbiter: three configurations (default, fixed priority, 3-cycle
// turnaround), each checked every cycle against a transfer-offset model plus literals.
module tb_ext_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic        req0_d [3];
    logic        req1_d [3];
    logic        rw0_d  [3];
    logic        rw1_d  [3];
    logic [31:0] addr0_d[3];
    logic [31:0] addr1_d[3];
    logic [31:0] wd0_d  [3];
    logic [31:0] wd1_d  [3];
    logic [7:0]  din_xor[3];

    logic        ack0_o [3];
    logic        ack1_o [3];
    logic        busy_o [3];
    logic [31:0] rdata_o[3];
    logic [7:0]  addr_o [3];
    logic [7:0]  dout_o [3];
    logic [7:0]  oe_o   [3];
    logic [1:0]  phase_o[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int TC = (gi == 2) ? 3 : 1;
        localparam bit FP = (gi == 1);

        ext_bus_arbiter_if bif();
        ext_bus_arbiter #(.TURN_CYCLES(TC), .FIXED_PRIO(FP)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bif)
        );

        assign bif.req0   = req0_d[gi];
        assign bif.req1   = req1_d[gi];
        assign bif.rw0    = rw0_d[gi];
        assign bif.rw1    = rw1_d[gi];
        assign bif.addr0  = addr0_d[gi];
        assign bif.addr1  = addr1_d[gi];
        assign bif.wdata0 = wd0_d[gi];
        assign bif.wdata1 = wd1_d[gi];
        assign ack0_o[gi]  = bif.ack0;
        assign ack1_o[gi]  = bif.ack1;
        assign busy_o[gi]  = bif.busy;
        assign rdata_o[gi] = bif.rdata;
        assign addr_o[gi]  = bif.bus_addr;
        assign dout_o[gi]  = bif.bus_dout;
        assign oe_o[gi]    = bif.bus_oe;
        assign phase_o[gi] = bif.bus_phase;

        // Model: m_t is the cycle offset since grant; 0..3 addr, then turn, rdata, done.
        bit          m_act, m_gnt, m_rw, m_last;
        int          m_t;
        logic [31:0] m_addr, m_wd, m_rdata, m_sh;

        initial begin : model
            m_act = 0; m_t = 0; m_gnt = 0; m_rw = 0; m_last = 1;
            m_addr = 0; m_wd = 0; m_rdata = 0; m_sh = 0;
            forever begin
                @(posedge clk);
                if (rst === 1'b1) begin
                    m_act = 0; m_t = 0; m_rdata = 0; m_last = 1;
                end else if (!m_act) begin
                    if (req0_d[gi] === 1'b1 || req1_d[gi] === 1'b1) begin
                        if (req0_d[gi] === 1'b1 && req1_d[gi] === 1'b1)
                            m_gnt = FP ? 1'b0 : !m_last;
                        else
                            m_gnt = (req1_d[gi] === 1'b1);
                        m_last = m_gnt;
                        m_rw   = m_gnt ? rw1_d[gi]   : rw0_d[gi];
                        m_addr = m_gnt ? addr1_d[gi] : addr0_d[gi];
                        m_wd   = m_gnt ? wd1_d[gi]   : wd0_d[gi];
                        m_act  = 1;
                        m_t    = 0;
                    end
                end else begin
                    if (m_rw && m_t >= 4 + TC && m_t < 8 + TC)
                        m_sh[8*(m_t-4-TC) +: 8] = bif.bus_din;
                    if (m_t == (m_rw ? 8 + TC : 4)) begin
                        m_act = 0;
                    end else begin
                        m_t++;
                        if (m_rw && m_t == 8 + TC) m_rdata = m_sh;
                    end
                end
            end
        end

        // Pins present 11,22,33,44 (xor din_xor) in read-data cycles, noise otherwise.
        initial begin : drv
            bif.bus_din = 8'h00;
            forever begin
                @(posedge clk);
                #1;
                if (m_act && m_rw && m_t >= 4 + TC && m_t < 8 + TC)
                    bif.bus_din = (8'h11 * 8'(m_t - 3 - TC)) ^ din_xor[gi];
                else
                    bif.bus_din = 8'($urandom);
            end
        end

        initial begin : cmp
            string      pfx;
            logic       e_ack0, e_ack1, e_busy;
            logic [7:0] e_addr, e_dout, e_oe;
            logic [1:0] e_phase, e_byte;
            pfx = $sformatf("u%0d.", gi);
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    e_ack0 = 0; e_ack1 = 0; e_busy = m_act;
                    e_addr = 0; e_dout = 0; e_oe = 0; e_phase = 0; e_byte = 0;
                    if (m_act) begin
                        if (m_t < 4) begin
                            e_phase = 2'b01;
                            e_byte  = 2'(m_t);
                            e_addr  = m_addr[8*m_t +: 8];
                            if (!m_rw) begin
                                e_dout = m_wd[8*m_t +: 8];
                                e_oe   = 8'hFF;
                            end
                        end else if (m_t == (m_rw ? 8 + TC : 4)) begin
                            e_ack0 = !m_gnt;
                            e_ack1 = m_gnt;
                        end else if (m_t < 4 + TC) begin
                            e_phase = 2'b10;
                        end else begin
                            e_phase = 2'b11;
                            e_byte  = 2'(m_t - 4 - TC);
                        end
                    end
                    chk({pfx, "ack0"},   32'(bif.ack0),      32'(e_ack0));
                    chk({pfx, "ack1"},   32'(bif.ack1),      32'(e_ack1));
                    chk({pfx, "busy"},   32'(bif.busy),      32'(e_busy));
                    chk({pfx, "rdata"},  bif.rdata,          m_rdata);
                    chk({pfx, "baddr"},  32'(bif.bus_addr),  32'(e_addr));
                    chk({pfx, "bdout"},  32'(bif.bus_dout),  32'(e_dout));
                    chk({pfx, "boe"},    32'(bif.bus_oe),    32'(e_oe));
                    chk({pfx, "bphase"}, 32'(bif.bus_phase), 32'(e_phase));
                    chk({pfx, "bbyte"},  32'(bif.bus_byte),  32'(e_byte));
                    chk({pfx, "twoacks"}, 32'(bif.ack0 & bif.ack1), 32'h0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_xfer(input int i, input bit p, input bit rw, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
        if (p) begin
            req1_d[i] = 1'b1; rw1_d[i] = rw; addr1_d[i] = a; wd1_d[i] = d;
        end else begin
            req0_d[i] = 1'b1; rw0_d[i] = rw; addr0_d[i] = a; wd0_d[i] = d;
        end
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((p ? ack1_o[i] : ack0_o[i]) === 1'b1) begin
                lat = k;
                break;
            end
        end
        tick();
        req0_d[i] = 1'b0;
        req1_d[i] = 1'b0;
    endtask

    logic [7:0] ea [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    logic [7:0] ed [4] = '{8'hBE, 8'hBA, 8'hFE, 8'hCA};
    int lat, na, nb;
    int seq[$];

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_d[i] = 0; req1_d[i] = 0; rw0_d[i] = 0; rw1_d[i] = 0;
            addr0_d[i] = 0; addr1_d[i] = 0; wd0_d[i] = 0; wd1_d[i] = 0; din_xor[i] = 0;
        end
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy",  32'(busy_o[i]),  0);
            chk("rst_ack0",  32'(ack0_o[i]),  0);
            chk("rst_oe",    32'(oe_o[i]),    0);
            chk("rst_phase", 32'(phase_o[i]), 0);
            chk("rst_rdata", rdata_o[i],      0);
        end
        tick();
        rst = 1'b0;
        tick();

        // Port 0 write on the default instance
        req0_d[0] = 1; rw0_d[0] = 0; addr0_d[0] = 32'h1234_5678; wd0_d[0] = 32'hCAFE_BABE;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) begin
                chk("t1_addr", 32'(addr_o[0]), 32'(ea[k-1]));
                chk("t1_dout", 32'(dout_o[0]), 32'(ed[k-1]));
                chk("t1_oe",   32'(oe_o[0]),   32'hFF);
            end
            if (k == 5) chk("t1_ack0", 32'(ack0_o[0]), 1);
        end
        tick();
        req0_d[0] = 0;

        // Port 1 read, pins 11,22,33,44
        din_xor[0] = 8'h00;
        req1_d[0] = 1; rw1_d[0] = 1; addr1_d[0] = 32'h0000_0010;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("t2_turn_phase", 32'(phase_o[0]), 2);
                chk("t2_turn_oe",    32'(oe_o[0]),    0);
            end
            if (k == 6) chk("t2_rd_phase", 32'(phase_o[0]), 3);
            if (k == 10) begin
                chk("t2_ack1",  32'(ack1_o[0]), 1);
                chk("t2_ack0",  32'(ack0_o[0]), 0);
                chk("t2_rdata", rdata_o[0],     32'h4433_2211);
            end
        end
        tick();
        req1_d[0] = 0;

        // Both held, round-robin: grants alternate 0,1,0,1
        req0_d[0] = 1; rw0_d[0] = 0; addr0_d[0] = 32'hA0A0_0001; wd0_d[0] = 32'h0000_1111;
        req1_d[0] = 1; rw1_d[0] = 0; addr1_d[0] = 32'hB0B0_0002; wd1_d[0] = 32'h0000_2222;
        seq.delete();
        for (int k = 0; k <= 23; k++) begin
            @(negedge clk);
            if (ack0_o[0] === 1'b1) seq.push_back(0);
            if (ack1_o[0] === 1'b1) seq.push_back(1);
        end
        tick();
        req0_d[0] = 0; req1_d[0] = 0;
        chk("t3_nacks", seq.size(), 4);
        for (int j = 0; j < seq.size() && j < 4; j++) chk("t3_order", seq[j], j % 2);

        // Fixed priority, both held: port 0 every time
        req0_d[1] = 1; rw0_d[1] = 0; addr0_d[1] = 32'h0000_0100; wd0_d[1] = 32'h1357_9BDF;
        req1_d[1] = 1; rw1_d[1] = 0; addr1_d[1] = 32'h0000_0200; wd1_d[1] = 32'h2468_ACE0;
        na = 0; nb = 0;
        for (int k = 0; k <= 23; k++) begin
            @(negedge clk);
            if (ack0_o[1] === 1'b1) na++;
            if (ack1_o[1] === 1'b1) nb++;
        end
        tick();
        req0_d[1] = 0; req1_d[1] = 0;
        chk("t4_ack0_cnt", na, 4);
        chk("t4_ack1_cnt", nb, 0);

        // Reset during read-data byte 2 aborts without ack
        din_xor[0] = 8'($urandom);
        req0_d[0] = 1; rw0_d[0] = 1; addr0_d[0] = 32'h0000_0F00;
        na = 0;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k == 7) chk("t5_byte1", 32'(phase_o[0]), 3);
            na += int'(ack0_o[0] === 1'b1);
            tick();
        end
        rst = 1'b1;
        req0_d[0] = 0;
        @(negedge clk);
        na += int'(ack0_o[0] === 1'b1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        na += int'(ack0_o[0] === 1'b1);
        chk("t5_no_ack", na, 0);
        chk("t5_busy",   32'(busy_o[0]), 0);
        chk("t5_rdata",  rdata_o[0],     0);
        chk("t5_oe",     32'(oe_o[0]),   0);
        tick();
        do_xfer(0, 1'b0, 1'b0, 32'h0000_0044, 32'h5555_AAAA, lat);
        chk("t5_fresh_lat", lat, 5);

        // TURN_CYCLES=3 read; addr0 changed mid-transfer must not reach the pins
        din_xor[2] = 8'h00;
        req0_d[2] = 1; rw0_d[2] = 1; addr0_d[2] = 32'h1234_5678;
        na = 0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) chk("t6_addr", 32'(addr_o[2]), 32'(ea[k-1]));
            if (ack0_o[2] === 1'b1) na++;
            if (k == 12) begin
                chk("t6_ack0",  32'(ack0_o[2]), 1);
                chk("t6_rdata", rdata_o[2],     32'h4433_2211);
            end
            tick();
            if (k == 1) addr0_d[2] = 32'hFFFF_FFFF;
        end
        req0_d[2] = 0;
        chk("t6_nacks", na, 1);

        // Mixed single transfers on every instance
        for (int r = 0; r < 9; r++) begin
            bit p, rw;
            int i;
            i = r % 3;
            p = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            din_xor[i] = 8'($urandom);
            do_xfer(i, p, rw, $urandom, $urandom, lat);
            chk("mix_lat", lat, rw ? (i == 2 ? 12 : 10) : 5);
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
